// File: rtl/quartsine_ctrl.sv
// Full-wave sine sequencer driving a 256x11 quarter-wave ROM.
// Mirrors the table per quadrant and emits signed 12-bit samples.
module quartsine_ctrl #(
  parameter int PHASE_W = 16,
  parameter int ROM_LAT = 1
) (
  input  logic                      clka,
  input  logic                      resetn,
  input  logic                      en,
  input  logic                      tune_wr,
  input  logic [PHASE_W-1:0]        tune,
  output logic                      rom_en,
  output logic [7:0]                rom_addr,
  input  logic [10:0]               rom_data,
  output logic signed [11:0]        sample,
  output logic                      sample_valid,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e               state_q, state_d;
  logic [PHASE_W-1:0]   acc_q, acc_d;
  logic [PHASE_W-1:0]   act_q, act_d;
  logic [PHASE_W-1:0]   pend_q, pend_d;
  logic                 pflag_q, pflag_d;
  logic [ROM_LAT:0]     vld_q, vld_d;
  logic [ROM_LAT:0]     neg_q, neg_d;
  logic [7:0]           addr_q, addr_d;
  logic [11:0]          smp_q, smp_d;
  logic                 svld_q, svld_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [PHASE_W:0]     sum;
  logic [1:0]           quad;
  logic [7:0]           idx;
  logic [PHASE_W-1:0]   wrap_tune;

  assign sum  = {1'b0, acc_q} + {1'b0, act_q};
  assign quad = acc_q[PHASE_W-1 -: 2];
  assign idx  = acc_q[PHASE_W-3 -: 8];
  // A write landing on a wrap/idle-entry edge bypasses the pending slot
  assign wrap_tune = tune_wr ? tune : (pflag_q ? pend_q : act_q);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    act_d   = act_q;
    pend_d  = pend_q;
    pflag_d = pflag_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    smp_d   = smp_q;
    svld_d  = 1'b0;
    vld_d   = {vld_q[ROM_LAT-1:0], 1'b0};
    neg_d   = {neg_q[ROM_LAT-1:0], 1'b0};
    if (vld_q[ROM_LAT]) begin
      smp_d  = neg_q[ROM_LAT] ? 12'(-{1'b0, rom_data})
                              : {1'b0, rom_data};
      svld_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (tune_wr) act_d = tune;
        if (en) begin
          state_d = RUN;
          acc_d   = '0;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = DRAIN;
          cnt_d   = '0;
          if (tune_wr) begin
            pend_d  = tune;
            pflag_d = 1'b1;
          end
        end else begin
          addr_d   = quad[0] ? ~idx : idx;
          vld_d[0] = 1'b1;
          neg_d[0] = quad[1];
          acc_d    = sum[PHASE_W-1:0];
          if (sum[PHASE_W]) begin
            act_d   = wrap_tune;
            pflag_d = 1'b0;
          end else if (tune_wr) begin
            pend_d  = tune;
            pflag_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == 2'(ROM_LAT)) begin
          state_d = IDLE;
          acc_d   = '0;
          smp_d   = '0;
          svld_d  = 1'b0;
          vld_d   = '0;
          neg_d   = '0;
          act_d   = wrap_tune;
          pflag_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 2'd1;
          if (tune_wr) begin
            pend_d  = tune;
            pflag_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      act_q   <= '0;
      pend_q  <= '0;
      pflag_q <= 1'b0;
      vld_q   <= '0;
      neg_q   <= '0;
      addr_q  <= '0;
      smp_q   <= '0;
      svld_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      vld_q   <= vld_d;
      neg_q   <= neg_d;
      addr_q  <= addr_d;
      smp_q   <= smp_d;
      svld_q  <= svld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign rom_en       = busy;
  assign rom_addr     = addr_q;
  assign sample       = smp_q;
  assign sample_valid = svld_q;

endmodule

// File: tb/tb_quartsine_ctrl.sv
// Scoreboard bench for quartsine_ctrl at ROM_LAT=1 and ROM_LAT=2.
// A phase-level model predicts samples; monitors pop and compare.
module tb_quartsine_ctrl;

  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          en = 1'b0;
  logic          tune_wr = 1'b0;
  logic [PW-1:0] tune = '0;
  int            vectors = 0;
  int            errors = 0;
  int            cyc = 0;
  int            rom [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int LAT = g + 1;
    logic        rom_en, busy, sample_valid;
    logic [7:0]  rom_addr;
    logic [10:0] rom_data, d1, d2;
    logic signed [11:0] sample;

    quartsine_ctrl #(.PHASE_W(PW), .ROM_LAT(LAT)) dut (
      .clka(clk), .resetn(resetn), .en(en), .tune_wr(tune_wr),
      .tune(tune), .rom_en(rom_en), .rom_addr(rom_addr),
      .rom_data(rom_data), .sample(sample),
      .sample_valid(sample_valid), .busy(busy)
    );

    always @(posedge clk) begin
      d1 <= 11'(rom[rom_addr]);
      d2 <= d1;
    end
    assign rom_data = (LAT == 1) ? d1 : d2;

    // Model: 0 idle, 1 running, 2 draining
    int      q[$];
    int      mode, dleft, start, quadr, ti, a, v, e;
    longint  ph, stp, pv;
    bit      pf, first;

    always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        mode = 0; ph = 0; stp = 0; pv = 0; pf = 0;
        first = 0; dleft = 0;
        q.delete();
      end else begin
        case (mode)
          0: begin
            if (tune_wr) stp = tune;
            if (en) begin
              mode = 1; ph = 0; start = cyc + 1; first = 1;
            end
          end
          1: begin
            if (!en) begin
              mode = 2; dleft = LAT + 1;
              if (tune_wr) begin pv = tune; pf = 1; end
            end else begin
              quadr = int'(ph / 16384);
              ti = int'((ph / 64) % 256);
              a = (quadr % 2 == 1) ? 255 - ti : ti;
              v = (quadr >= 2) ? -rom[a] : rom[a];
              q.push_back(v);
              ph = ph + stp;
              if (ph >= 65536) begin
                ph = ph - 65536;
                stp = tune_wr ? longint'(tune) : (pf ? pv : stp);
                pf = 0;
              end else if (tune_wr) begin
                pv = tune; pf = 1;
              end
            end
          end
          default: begin
            dleft--;
            if (dleft == 0) begin
              mode = 0; ph = 0;
              stp = tune_wr ? longint'(tune) : (pf ? pv : stp);
              pf = 0;
            end else if (tune_wr) begin
              pv = tune; pf = 1;
            end
          end
        endcase
      end
    end

    always @(negedge clk) begin
      if (resetn) begin
        vectors++;
        if (busy !== (mode != 0) || rom_en !== (mode != 0)) begin
          errors++;
          $display("FAIL busy lat%0d t=%0t: busy=%b rom_en=%b required=%b",
                   LAT, $time, busy, rom_en, mode != 0);
        end
        if (sample_valid === 1'b1) begin
          vectors++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL extra_valid lat%0d t=%0t: sample=%0d with none expected",
                     LAT, $time, sample);
          end else begin
            e = q.pop_front();
            if ($signed(sample) !== e) begin
              errors++;
              $display("FAIL sample lat%0d t=%0t: got %0d required %0d",
                       LAT, $time, sample, e);
            end
          end
          if (first) begin
            first = 0;
            vectors++;
            if (cyc - start != LAT + 2) begin
              errors++;
              $display("FAIL latency lat%0d: got %0d cycles required %0d",
                       LAT, cyc - start, LAT + 2);
            end
          end
        end
        if (mode == 0) begin
          vectors++;
          if (sample !== 12'sd0 || sample_valid !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL idle lat%0d t=%0t: sample=%0d valid=%b pending=%0d required 0/0/0",
                     LAT, $time, sample, sample_valid, q.size());
          end
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    logic [43:0] o;
    o = {g_lat[0].busy, g_lat[0].rom_en, g_lat[0].sample_valid,
         g_lat[0].sample, g_lat[0].rom_addr,
         g_lat[1].busy, g_lat[1].rom_en, g_lat[1].sample_valid,
         g_lat[1].sample, g_lat[1].rom_addr};
    vectors++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_%s: outputs=%h required 0", tag, o);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) rom[i] = $urandom_range(1, 2046);
    rom[0] = 0;
    rom[255] = 2047;
    ticks(2);
    #1 check_zero("por");
    resetn = 1'b1;
    ticks(3);
    // Full period at tune=64, retune to 128 at sample 100
    tune = 16'd64; tune_wr = 1'b1;
    ticks(1);
    tune_wr = 1'b0; en = 1'b1;
    ticks(101);
    tune = 16'd128; tune_wr = 1'b1;
    ticks(1);
    tune_wr = 1'b0; tune = 16'd7;
    ticks(1600);
    // Stop, then an en pulse inside drain
    en = 1'b0;
    ticks(1);
    en = 1'b1;
    ticks(1);
    en = 1'b0;
    ticks(8);
    // Random segments with frequent wrap-edge writes
    for (int r = 0; r < 14; r++) begin
      case (r % 4)
        0: tune = 16'h4000;
        1: tune = 16'h2000;
        2: tune = 16'd0;
        default: tune = 16'($urandom);
      endcase
      tune_wr = 1'b1;
      ticks(1);
      tune_wr = 1'b0; en = 1'b1;
      n = $urandom_range(8, 150);
      repeat (n) begin
        tune_wr = ($urandom_range(0, 2) == 0);
        tune = (r % 2 == 0) ? 16'($urandom_range(1, 4) * 16'h1000)
                            : 16'($urandom);
        ticks(1);
      end
      tune_wr = 1'b0; en = 1'b0;
      ticks(1);
      en = ($urandom_range(0, 1) == 1);
      tune_wr = ($urandom_range(0, 1) == 1);
      tune = 16'($urandom);
      ticks(1);
      en = 1'b0; tune_wr = 1'b0;
      ticks(6);
    end
    // Abort mid-stream with reset
    tune = 16'd300; tune_wr = 1'b1;
    ticks(1);
    tune_wr = 1'b0; en = 1'b1;
    ticks(20);
    #2 resetn = 1'b0;
    #1 check_zero("mid");
    en = 1'b0;
    ticks(2);
    resetn = 1'b1;
    ticks(4);
    check_zero("post");
    tune = 16'd64; tune_wr = 1'b1;
    ticks(1);
    tune_wr = 1'b0; en = 1'b1;
    ticks(40);
    en = 1'b0;
    ticks(8);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/quartsine_ctrl.md
# quartsine_ctrl

Full-wave sine sequencer for the 256-entry × 11-bit quarter-wave sine ROM. A phase accumulator drives the ROM address with quadrant mirroring. The block negates ROM output in the lower half-wave and emits a signed 12-bit sample stream aligned to the ROM read latency. It sits between the tone/config logic and the ROM instance, and is the only master of the ROM port.

## Interface
- PHASE_W, 16, phase accumulator width (≥10); top 2 bits = quadrant, next 8 bits = table index
- ROM_LAT, 1, ROM read latency in cycles from address register to valid rom_data (1 or 2)
- clka  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- en  in  1  run request; level-sensitive
- tune_wr  in  1  single-cycle strobe: capture tune
- tune  in  PHASE_W  phase increment per sample
- rom_en  out  1  ROM enable
- rom_addr  out  8  ROM address, registered
- rom_data  in  11  ROM read data, unsigned magnitude
- sample  out  12  signed two's-complement sine sample
- sample_valid  out  1  sample qualifier, one pulse per sample
- busy  out  1  high in RUN and DRAIN

## Operation
- States:
  - IDLE → RUN: on an edge with en=1; acc<=0.
  - RUN → DRAIN: on an edge with en=0.
  - DRAIN → IDLE: after exactly ROM_LAT+1 cycles.
- en is ignored in DRAIN. Re-assertion takes effect only from IDLE.
- RUN, every edge:
  - rom_addr <= map(acc)
  - sign/valid pipe stage 0 <= (acc[PHASE_W-1], 1)
  - acc <= acc + tune_act, modulo 2^PHASE_W
- Address map: q=acc[PHASE_W-1:PHASE_W-2], i=acc[PHASE_W-3:PHASE_W-10].
  - q=0 → i, positive
  - q=1 → 255−i, positive
  - q=2 → i, negative
  - q=3 → 255−i, negative
  - Peak and zero entries repeat at quadrant joins; this is intended.
- Output stage: when valid pipe stage ROM_LAT is high, sample <= neg ? −{0,rom_data} : {0,rom_data} and sample_valid <= 1; otherwise sample_valid <= 0 and sample holds.
  - Range is −2047..+2047. Negating 0 yields 0.
- Tuning:
  - IDLE: tune_wr loads tune_act directly.
  - RUN/DRAIN: tune_wr loads tune_pend and sets pend_flag.
  - tune_act <= tune_pend only on the edge where acc+tune_act carries out (wrap). pend_flag clears on that edge.
  - tune_wr on the wrap edge: that cycle's tune input goes straight to tune_act.
  - Entry into IDLE applies any pending value.
- Entering IDLE: acc<=0, sample<=0, pipes cleared.
- rom_en = busy.
- tune=0 in RUN: the same address repeats; valid samples still stream.

## Timing
- Reset (async, immediate), all zero: acc, rom_addr, sample, sample_valid, busy, rom_en, tune_act, tune_pend, pend_flag, pipes. State = IDLE.
- Edge E0 samples en=1. rom_addr for acc=0 is presented after E1. First sample_valid is after E(ROM_LAT+2); steady state is one sample per cycle.
- Address-to-sample latency: ROM_LAT+1 cycles from the edge that registers rom_addr.
- Stop: after the edge that samples en=0, no new address is issued. Exactly ROM_LAT+1 further sample_valid pulses follow, busy falls, then sample=0.
- Reset mid-RUN/DRAIN aborts the stream with no further valid pulses. The first edge after resetn rises behaves as from IDLE.
- No combinational paths from inputs to outputs.

## Test plan
- Reset: assert resetn=0 mid-stream → all outputs 0 within the same cycle; release with en=0 → outputs stay 0 and busy=0.
- Full period, PHASE_W=16, ROM_LAT=1, tune=64 (set in IDLE):
  - en=1 → first sample_valid 3 cycles after the en edge.
  - rom_addr sequence 0..255, 255..0, 0..255, 255..0 (1024 samples).
  - Samples positive for the first 512, negated for the last 512.
  - Sample 256 equals +rom[255]; sample 768 equals −rom[255].
- Glitch-free retune: tune=64 running, tune_wr with tune=128 at sample 100 → step stays 1 address/cycle until acc wraps at sample 1024, then the period becomes 512.
- Stop/drain: drop en during RUN → exactly 2 further valid pulses (ROM_LAT=1), busy low on the next cycle, sample=0. en pulse during DRAIN → ignored.
- Latency parameter, ROM_LAT=2: repeat the full-period test → first valid 4 cycles after the en edge; 3 drain pulses on stop; sample values identical.
- Wrap + tune_wr same edge: tune_wr coincides with the wrap edge → new value applied on that edge, no intermediate step size.
